// File: rtl/fpu_types_pkg.sv
// Shared half-precision field widths, the per-entry class type and the
// special encodings produced by the upstream multiplier.
package fpu_types_pkg;

    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;
    localparam int HALF_CLASS_W    = 5;

    localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN     = 16'hFFFF;
    localparam logic [HALF_FLOAT_W-1:0] HALF_SNAN_OVF = 16'hFDFF;
    localparam logic [HALF_FLOAT_W-1:0] HALF_SIGN_MASK = 16'h8000;

    // One-hot (or all-zero for normals); zero sits in the MSB.
    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic qnan;
        logic snan;
    } half_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Purely combinational half-precision classifier: zero, subnormal,
// infinity, quiet NaN, signalling NaN, or none of these for normals.
module fp16_classify
    import fpu_types_pkg::*;
(
    input  logic [HALF_FLOAT_W-1:0] i_product,
    output half_class_t             o_class
);

    logic [HALF_FLOAT_W-1:0]    w_magnitude;
    logic [HALF_EXPONENT_W-1:0] w_exp;
    logic [HALF_FRACTION_W-1:0] w_mant;
    logic                       w_exp_zero;
    logic                       w_exp_ones;
    logic                       w_mant_zero;

    // Sign never affects the class, so strip it before splitting fields.
    assign w_magnitude = i_product & ~HALF_SIGN_MASK;
    assign w_exp       = w_magnitude[HALF_FLOAT_W-2 -: HALF_EXPONENT_W];
    assign w_mant      = w_magnitude[HALF_FRACTION_W-1:0];

    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_ones  = (w_exp == '1);
    assign w_mant_zero = (w_mant == '0);

    always_comb begin
        o_class      = '0;
        o_class.zero = w_exp_zero &  w_mant_zero;
        o_class.sub  = w_exp_zero & ~w_mant_zero;
        o_class.inf  = w_exp_ones &  w_mant_zero;
        o_class.qnan = w_exp_ones &  w_mant[HALF_FRACTION_W-1];
        o_class.snan = w_exp_ones & ~w_mant[HALF_FRACTION_W-1] & ~w_mant_zero;
    end

endmodule

// File: rtl/fp16_mult_result_stage.sv
// Result queue behind the fp16 multiplier: classifies each accepted product,
// buffers it with its class in a FWFT FIFO, and keeps sticky flags and an SNaN count.
module fp16_mult_result_stage
    import fpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_valid,
    input  logic [HALF_FLOAT_W-1:0]    in_product,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HALF_FLOAT_W-1:0]    out_result,
    output logic [HALF_CLASS_W-1:0]    out_flags,
    output logic [HALF_CLASS_W-1:0]    sticky_flags,
    input  logic                       flags_clear,
    output logic [CNT_W-1:0]           snan_count,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [HALF_FLOAT_W-1:0] r_data  [DEPTH];
    half_class_t             r_class [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [HALF_CLASS_W-1:0] r_sticky;
    logic [CNT_W-1:0]        r_snan_cnt;

    half_class_t             w_class;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [HALF_CLASS_W-1:0] w_sticky_next;
    logic [CNT_W-1:0]        w_cnt_base;
    logic [CNT_W-1:0]        w_cnt_next;

    fp16_classify u_classify (
        .i_product (in_product),
        .o_class   (w_class)
    );

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = out_ready & ~w_empty;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign occupancy = r_count;

    // Storage is never reset; gating by emptiness keeps the head clean.
    assign out_result = w_empty ? '0 : r_data[r_rd_ptr];
    assign out_flags  = w_empty ? '0 : r_class[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_data[r_wr_ptr]  <= in_product;
            r_class[r_wr_ptr] <= w_class;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear wipes history but a product accepted in the same cycle still counts.
    assign w_sticky_next = (flags_clear ? '0 : r_sticky) | (w_push ? w_class : '0);
    assign w_cnt_base    = flags_clear ? '0 : r_snan_cnt;
    assign w_cnt_next    = (w_push && w_class.snan && !(&w_cnt_base))
                           ? w_cnt_base + CNT_W'(1) : w_cnt_base;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sticky   <= '0;
            r_snan_cnt <= '0;
        end else begin
            r_sticky   <= w_sticky_next;
            r_snan_cnt <= w_cnt_next;
        end
    end

    assign sticky_flags = r_sticky;
    assign snan_count   = r_snan_cnt;

endmodule

// File: tb/tb_fp16_mult_result_stage.sv
// Randomized plus directed bench: a queue-based scoreboard with an
// arithmetic classifier model checks every pop and the flag/count state.
module tb_fp16_mult_result_stage;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        flags_clear = 1'b0;
    logic [CNT_W-1:0] snan_count;
    logic [$clog2(DEPTH):0] occupancy;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic [4:0]  m_sticky = '0;
    int          m_cnt = 0;

    fp16_mult_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_product   (in_product),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flags_clear  (flags_clear),
        .snan_count   (snan_count),
        .occupancy    (occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Class from the numeric value of the exponent and fraction fields.
    function automatic logic [4:0] ref_class(input logic [15:0] v);
        int e;
        int m;
        e = int'((v >> 10) % 32);
        m = int'(v % 1024);
        if (e == 0)  return (m == 0) ? 5'b10000 : 5'b01000;
        if (e == 31) begin
            if (m == 0)    return 5'b00100;
            if (m >= 512)  return 5'b00010;
            return 5'b00001;
        end
        return 5'b00000;
    endfunction

    // Monitor/scoreboard: inputs are stable here until the next rising edge.
    always @(negedge CLK) begin
        logic [4:0]  cls;
        logic [20:0] ent;
        bit          push;
        int          occ;
        if (!nRST) begin
            exp_q.delete();
            m_sticky = '0;
            m_cnt    = 0;
        end else begin
            occ = exp_q.size();
            check("occupancy", 32'(occupancy), 32'(occ));
            check("in_ready", 32'(in_ready), 32'(occ != DEPTH));
            check("out_valid", 32'(out_valid), 32'(occ != 0));
            check("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
            check("snan_count", 32'(snan_count), 32'(m_cnt));
            if (occ == 0) begin
                check("empty_result", 32'(out_result), 32'h0);
                check("empty_flags", 32'(out_flags), 32'h0);
            end
            push = in_valid && (occ < DEPTH);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_result), 32'hDEAD);
                end else begin
                    ent = exp_q.pop_front();
                    check("out_result", 32'(out_result), 32'(ent[20:5]));
                    check("out_flags", 32'(out_flags), 32'(ent[4:0]));
                end
            end
            cls = ref_class(in_product);
            m_sticky = (flags_clear ? 5'b0 : m_sticky) | (push ? cls : 5'b0);
            if (flags_clear) m_cnt = 0;
            if (push && cls == 5'b00001 && m_cnt < (2**CNT_W - 1)) m_cnt++;
            if (push) exp_q.push_back({in_product, cls});
        end
    end

    task automatic step(input logic v, input logic [15:0] p, input logic r, input logic c);
        in_valid    = v;
        in_product  = p;
        out_ready   = r;
        flags_clear = c;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] rand_product();
        logic [15:0] s;
        logic [15:0] m;
        s = 16'($urandom_range(0, 1)) << 15;
        m = 16'($urandom_range(1, 511));
        case ($urandom_range(0, 5))
            0: return 16'($urandom);
            1: return s | 16'h7C00;
            2: return s | 16'h7C00 | m;
            3: return s | 16'h7E00 | m;
            4: return s | m;
            default: return s;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        step(0, 16'h0, 0, 0);

        // single push, one-cycle latency
        step(1, 16'h3C00, 0, 0);
        check("d1_valid", 32'(out_valid), 32'h1);
        check("d1_result", 32'(out_result), 32'h3C00);
        check("d1_flags", 32'(out_flags), 32'h0);
        check("d1_occ", 32'(occupancy), 32'h1);
        step(0, 16'h0, 1, 0);

        // fill to full, fifth held until a pop
        for (int i = 0; i < 4; i++) step(1, 16'h4000 + 16'(i), 0, 0);
        check("d2_in_ready", 32'(in_ready), 32'h0);
        check("d2_occ", 32'(occupancy), 32'h4);
        step(1, 16'h4004, 0, 0);
        check("d2_held_occ", 32'(occupancy), 32'h4);
        step(1, 16'h4004, 1, 0);
        check("d2_pop_occ", 32'(occupancy), 32'h3);
        step(1, 16'h4004, 0, 0);
        check("d2_refill_occ", 32'(occupancy), 32'h4);
        repeat (4) step(0, 16'h0, 1, 0);

        // snan then qnan
        step(0, 16'h0, 0, 1);
        step(1, 16'hFDFF, 0, 0);
        step(1, 16'hFFFF, 0, 0);
        check("d3_head_flags", 32'(out_flags), 32'h01);
        check("d3_sticky", 32'(sticky_flags), 32'h03);
        check("d3_snan_cnt", 32'(snan_count), 32'h1);
        step(0, 16'h0, 1, 0);
        check("d3_second_flags", 32'(out_flags), 32'h02);
        step(0, 16'h0, 1, 0);

        // clear coinciding with a push
        step(0, 16'h0, 0, 1);
        step(1, 16'h7C01, 0, 0);
        check("d4_prior_sticky", 32'(sticky_flags), 32'h01);
        step(1, 16'h7C00, 1, 1);
        check("d4_sticky", 32'(sticky_flags), 32'h04);
        check("d4_snan_cnt", 32'(snan_count), 32'h0);
        step(0, 16'h0, 1, 0);

        // streaming at occupancy 2 across pointer wrap
        step(1, 16'h0000, 0, 0);
        step(1, 16'h0001, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, (i % 2 == 0) ? 16'h0000 : 16'h0001, 1, 0);
            check("d5_occ", 32'(occupancy), 32'h2);
        end
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_product(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (DEPTH) step(0, 16'h0, 1, 0);

        // saturate the counter, leave 3 entries, then reset mid-cycle
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 16'h7C00 | 16'($urandom_range(1, 511)), 1, 0);
        step(1, 16'hFDFF, 0, 0);
        step(1, 16'hFDFF, 0, 0);
        check("d6_occ", 32'(occupancy), 32'h3);
        check("d6_snan_sat", 32'(snan_count), 32'hFF);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("d6_rst_occ", 32'(occupancy), 32'h0);
        check("d6_rst_valid", 32'(out_valid), 32'h0);
        check("d6_rst_snan", 32'(snan_count), 32'h0);
        check("d6_rst_ready", 32'(in_ready), 32'h1);
        check("d6_rst_sticky", 32'(sticky_flags), 32'h0);
        @(negedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
        step(1, 16'h3C00, 0, 0);
        check("d6_after_result", 32'(out_result), 32'h3C00);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_mult_result_stage.md
FP16_MULT_RESULT_STAGE -- requirements
Module: fp16_mult_result_stage

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, width of the SNaN event counter.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  product from upstream half-precision multiplier is valid.
REQ-006 in_product  input  HALF_FLOAT_W  multiplier product.
REQ-007 in_ready  output  1  stage can accept a product this cycle.
REQ-008 out_valid  output  1  head entry is valid.
REQ-009 out_ready  input  1  consumer takes head entry this cycle.
REQ-010 out_result  output  HALF_FLOAT_W  head entry product, unmodified.
REQ-011 out_flags  output  5  head entry class {zero, sub, inf, qnan, snan} (bit 4 = zero).
REQ-012 sticky_flags  output  5  OR of classes of all accepted products since last clear.
REQ-013 flags_clear  input  1  synchronous clear of sticky_flags and snan_count.
REQ-014 snan_count  output  CNT_W  saturating count of accepted SNaN-class products.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL equal (occupancy != DEPTH); no push while full, even with simultaneous pop.
REQ-018 out_valid SHALL equal (occupancy != 0); no same-cycle bypass, so push-to-out_valid latency is exactly 1 cycle.
REQ-019 Queue is FIFO-ordered; head is combinationally presented (first-word fall-through from storage).
REQ-020 Read/write pointers wrap modulo DEPTH; simultaneous push and pop leaves occupancy unchanged.
REQ-021 Classification is computed at push time and stored with the entry: exp = bits[14:10], mant = bits[9:0].
REQ-022 zero: exp==0 and mant==0 (either sign); sub: exp==0 and mant!=0.
REQ-023 inf: exp==5'h1F and mant==0; qnan: exp==5'h1F and mant[9]==1.
REQ-024 snan: exp==5'h1F, mant[9]==0, mant!=0 (covers multiplier overflow code 16'hFDFF).
REQ-025 Exactly one or zero class bits set per entry; normal values carry 5'b0.
REQ-026 sticky_flags next = (flags_clear ? 0 : sticky_flags) | (push ? new_class : 0); a same-cycle push survives a clear.
REQ-027 snan_count next = (flags_clear ? 0 : snan_count) + (push && snan ? 1 : 0), saturating at all-ones.
REQ-028 out_result/out_flags are don't-care when out_valid==0 but SHALL not be X after reset.

Reset
REQ-029 nRST low SHALL asynchronously force: pointers 0, occupancy 0, in_ready 1, out_valid 0, sticky_flags 0, snan_count 0.
REQ-030 Reset mid-operation discards all queued entries; storage array need not be reset but outputs read as 0 while empty.

Structure
REQ-031 HALF_FLOAT_W, HALF_EXPONENT_W, HALF_FRACTION_W and a new packed typedef half_class_t (5 flag bits) belong in fpu_types_pkg.
REQ-032 Constants HALF_QNAN (16'hFFFF) and HALF_SNAN_OVF (16'hFDFF) belong in fpu_types_pkg.
REQ-033 Classification is one combinational sub-module fp16_classify (product in, half_class_t out).
REQ-034 Queue storage, pointers and counters live in the top module; no other sub-modules.

Verification
REQ-035 Push 16'h3C00 with out_ready=0 -> next cycle out_valid=1, out_result=16'h3C00, out_flags=0, occupancy=1.
REQ-036 Push 5 products with out_ready=0 -> after 4 pushes in_ready=0, occupancy=4, 5th held until one pop, order preserved.
REQ-037 Push 16'hFDFF then 16'hFFFF -> out_flags snan then qnan, sticky_flags=5'b00011, snan_count=1.
REQ-038 flags_clear asserted same cycle as push of 16'h7C00 with prior sticky=5'b00001 -> sticky_flags=5'b00100, snan_count=0.
REQ-039 Continuous push/pop of 10 alternating values 16'h0000, 16'h0001 at occupancy 2 -> pointers wrap, flags zero/sub alternate, occupancy stays 2.
REQ-040 Assert nRST low asynchronously with 3 entries and snan_count=300 saturated at 255 -> immediately occupancy=0, out_valid=0, snan_count=0, in_ready=1.
